fetch_queue: RTL

//  Next-generation IF stage: owns the PC, issues in-order requests on the instruction bus
//  (addr/data handshake) and buffers returned instructions in a DEPTH-entry queue.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_queue_if.sv | 27 ++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_queue.sv | 119 +++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
// The entry record travels from the bus response side to decode unchanged.
package fetch_pkg;

  localparam int          FETCH_DEPTH           = 4;
  localparam int          FETCH_MAX_OUTSTANDING = 2;
  localparam logic [31:0] FETCH_RESET_PC        = 32'hbfc00000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] raw_instr;
    logic        adel;
  } fetch_entry_t;

  function automatic fetch_entry_t make_entry(input logic [31:0] pc,
                                              input logic [31:0] instr,
                                              input logic        adel);
    fetch_entry_t e;
    e.pc        = pc;
    e.pcplus4   = pc + 32'd4;
    e.raw_instr = instr;
    e.adel      = adel;
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-bus, redirect and decode-side signals of the fetch queue.
// master = fetch_queue itself, slave = the surrounding bus/decode/redirect logic.
interface fetch_queue_if;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pcplus4;
  logic [31:0] out_instr;
  logic        out_adel;

  modport master (
    output ireq_valid, ireq_addr, out_valid, out_pc, out_pcplus4, out_instr, out_adel,
    input  ireq_ready, iresp_valid, iresp_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  ireq_valid, ireq_addr, out_valid, out_pc, out_pcplus4, out_instr, out_adel,
    output ireq_ready, iresp_valid, iresp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Generic circular buffer with push/pop/flush; head is read straight from storage.
// Push into a full buffer is accepted only when a pop frees the slot in the same cycle.
module fetch_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  T                       push_dat,
  output T                       head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// IF stage: owns the PC, issues in-order bus requests, queues responses for decode.
// Define FETCH_ADDR_CHECK_EN to turn a misaligned PC into a single adel entry and halt fetch.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH           = FETCH_DEPTH,
  parameter int          MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING,
  parameter logic [31:0] RESET_PC        = FETCH_RESET_PC
) (
  input logic           clk,
  input logic           resetn,
  fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(MAX_OUTSTANDING) + 1;

  logic [31:0]   pc;
  logic          started;
  logic          halted;
  logic          aligned;
  logic [TW-1:0] outstanding;
  logic [TW-1:0] drop;
  logic          req_ok, req_fire, resp_keep, adel_push, q_push, tag_pop;

  fetch_entry_t  q_in, q_head;
  logic [CW-1:0] q_count;
  logic          q_empty, q_full;
  logic [31:0]   tag_pc;
  logic [TW-1:0] tag_count;
  logic          tag_empty, tag_full;

  // A slot is reserved in the queue for every request in flight, so responses never overflow.
  assign req_ok = started && !halted && aligned
                  && (int'(outstanding) < MAX_OUTSTANDING)
                  && (int'(q_count) + int'(outstanding) < DEPTH);

  assign bus.ireq_valid = !bus.redirect_valid && req_ok;
  assign bus.ireq_addr  = pc;
  assign req_fire       = bus.ireq_valid && bus.ireq_ready;
  assign tag_pop        = bus.iresp_valid && (drop == '0);
  assign resp_keep      = tag_pop && !bus.redirect_valid;
  assign q_push         = resp_keep || adel_push;
  assign q_in           = adel_push ? make_entry(pc, 32'h0, 1'b1)
                                    : make_entry(tag_pc, bus.iresp_data, 1'b0);

`ifdef FETCH_ADDR_CHECK_EN
  assign aligned   = (pc[1:0] == 2'b00);
  assign adel_push = started && !halted && !aligned && !bus.redirect_valid
                     && (outstanding == '0) && !q_full;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                 halted <= 1'b0;
    else if (bus.redirect_valid) halted <= 1'b0;
    else if (adel_push)          halted <= 1'b1;
  end

  assign bus.out_adel = q_head.adel;
`else
  assign aligned      = 1'b1;
  assign adel_push    = 1'b0;
  assign halted       = 1'b0;
  assign bus.out_adel = 1'b0;
`endif

  fetch_fifo #(.T(logic [31:0]), .DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk(clk), .resetn(resetn),
    .push(req_fire), .pop(tag_pop), .flush(bus.redirect_valid),
    .push_dat(pc), .head_dat(tag_pc),
    .full(tag_full), .empty(tag_empty), .count(tag_count)
  );

  fetch_fifo #(.T(fetch_entry_t), .DEPTH(DEPTH)) u_entry_fifo (
    .clk(clk), .resetn(resetn),
    .push(q_push), .pop(bus.out_ready), .flush(bus.redirect_valid),
    .push_dat(q_in), .head_dat(q_head),
    .full(q_full), .empty(q_empty), .count(q_count)
  );

  assign bus.out_valid   = !q_empty;
  assign bus.out_pc      = q_head.pc;
  assign bus.out_pcplus4 = q_head.pcplus4;
  assign bus.out_instr   = q_head.raw_instr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc          <= RESET_PC;
      started     <= 1'b0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      started <= 1'b1;
      if (bus.redirect_valid) begin
        pc <= bus.redirect_pc;
        // Everything still in flight is stale, including responses already marked for dropping.
        outstanding <= outstanding - TW'(bus.iresp_valid);
        drop        <= outstanding - TW'(bus.iresp_valid);
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        outstanding <= outstanding + TW'(req_fire) - TW'(bus.iresp_valid);
        if (bus.iresp_valid && (drop != '0)) drop <= drop - 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  a_no_unsolicited: assert property (@(posedge clk) disable iff (!resetn)
    bus.iresp_valid |-> (outstanding != '0));
  a_tag_live:       assert property (@(posedge clk) disable iff (!resetn)
    tag_count == outstanding - drop);
  a_tag_bounds:     assert property (@(posedge clk) disable iff (!resetn)
    !(req_fire && tag_full) && !(tag_pop && tag_empty));
  a_no_overflow:    assert property (@(posedge clk) disable iff (!resetn)
    q_push |-> (!q_full || bus.out_ready));
`ifndef FETCH_ADDR_CHECK_EN
  a_no_adel:        assert property (@(posedge clk) disable iff (!resetn)
    bus.out_valid |-> !q_head.adel);
`endif
`endif
endmodule
